mem_line_responder: RTL and testbench

//   Memory-side responder for the 128-bit line interface driven by the L2 cache:

---
 rtl/mem_line_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_line_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Memory-side responder for the 128-bit line interface below the L2 cache.
// Accepts one read or write line request at a time, waits LATENCY cycles, then
// pulses mem_ready for one cycle. Lines live in an internal array that is not
// cleared by reset (contents survive a reset pulse).
//
// Handshake: the requester raises mem_read or mem_write with mem_addr/mem_wdata
// and holds all of them stable until it observes mem_ready=1. mem_ready is a
// one-cycle pulse; a request still high during that cycle belongs to the
// transaction just completing and is not sampled again. The next request is
// sampled at the first edge after the ready cycle. Dropping the request or
// changing addr/op while waiting is a protocol violation (proto_err, sticky).
//
// Ports
//   clk           rising-edge clock
//   proc_reset_n  asynchronous active-low reset
//   mem_read      read-line request
//   mem_write     write-line request (wins if both are high)
//   mem_addr      28-bit line address, low ADDR_W bits index the array
//   mem_wdata     128-bit write line
//   mem_rdata     128-bit read line, valid while mem_ready=1 for a read
//   mem_ready     one-cycle completion pulse
//   proto_err     sticky protocol-violation flag
//   rd_cnt        completed reads, saturating
//   wr_cnt        completed writes, saturating
//   dbg_state     current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// -----------------------------------------------------------------------------
module mem_line_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [27:0]      mem_addr,
  input  logic [127:0]     mem_wdata,
  output logic [127:0]     mem_rdata,
  output logic             mem_ready,
  output logic             proto_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [1:0]       dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Wait counter only needs to hold LATENCY-2.
  localparam int LAT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;

  // Latched transaction. The full address and raw op pair are kept so that a
  // change while waiting can be detected, not only a change of the index.
  logic [27:0]        addr_q;
  logic [1:0]         op_pair_q;
  logic               wr_q;
  logic [127:0]       wdata_q;

  logic [127:0]       rdata_q;
  logic               ready_q, ready_d;
  logic               perr_q, perr_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic [127:0]       mem_q [DEPTH];

  logic               req;
  logic               capture;
  logic               enter_done;
  logic               held_changed;
  logic               cur_wr;
  logic [ADDR_W-1:0]  cur_idx;
  logic [127:0]       cur_wdata;
  logic               commit_wr;
  logic               load_rdata;

  assign req = mem_read | mem_write;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (LATENCY <= 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A dropped request aborts even when the count has just expired.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    capture      = (state_q == S_IDLE) && req;
    enter_done   = (state_d == S_DONE) && (state_q != S_DONE);
    held_changed = (state_q == S_WAIT) && req &&
                   (({mem_read, mem_write} != op_pair_q) || (mem_addr != addr_q));

    // With LATENCY=1 the DONE entry happens on the sampling edge itself, so the
    // live inputs are used; otherwise the latched transaction is.
    if (state_q == S_IDLE) begin
      cur_wr    = mem_write;
      cur_idx   = mem_addr[ADDR_W-1:0];
      cur_wdata = mem_wdata;
    end else begin
      cur_wr    = wr_q;
      cur_idx   = addr_q[ADDR_W-1:0];
      cur_wdata = wdata_q;
    end

    // Reset is folded in so a request present during reset cannot commit.
    commit_wr  = enter_done && cur_wr && proc_reset_n;
    load_rdata = enter_done && !cur_wr;

    ready_d = enter_done;

    perr_d = perr_q;
    if ((state_q == S_IDLE) && mem_read && mem_write) perr_d = 1'b1;
    if ((state_q == S_WAIT) && !req)                  perr_d = 1'b1;
    if (held_changed)                                 perr_d = 1'b1;

    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (enter_done) begin
      if (cur_wr) begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      addr_q    <= '0;
      op_pair_q <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      if (capture) begin
        addr_q    <= mem_addr;
        op_pair_q <= {mem_read, mem_write};
        wr_q      <= mem_write;
        wdata_q   <= mem_wdata;
      end
      if (load_rdata) begin
        rdata_q <= mem_q[cur_idx];
      end
      ready_q  <= ready_d;
      perr_q   <= perr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Line array: no reset, contents persist across proc_reset_n.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign proto_err = perr_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_line_responder
//
// Directed bench for mem_line_responder. Two instances share clock and reset:
// u_dut with LATENCY=4 and u_dut1 with LATENCY=1. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Cycle n of a transaction is
// the n-th falling edge after the request was driven, so mem_ready is expected
// at n == LATENCY.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;

  localparam int CNT_W = 16;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D5 = 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5;
  localparam logic [127:0] D7 = 128'h77777777_00000007_DEADBEEF_07070707;
  localparam logic [127:0] DA = 128'hAAAA0403_11112222_33334444_55556666;
  localparam logic [127:0] DB = 128'hBBBB0009_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] DP = 128'h20202020_50505050_FEEDFACE_00000020;
  localparam logic [127:0] DQ = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] DE = 128'hE1E1E1E1_0F0F0F0F_13579BDF_2468ACE0;

  // clock / reset
  logic clk = 1'b0;
  logic proc_reset_n = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic             mem_read, mem_write;
  logic [27:0]      mem_addr;
  logic [127:0]     mem_wdata, mem_rdata;
  logic             mem_ready, proto_err;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic [1:0]       dbg_state;

  // LATENCY=1 instance
  logic             l1_read, l1_write;
  logic [27:0]      l1_addr;
  logic [127:0]     l1_wdata, l1_rdata;
  logic             l1_ready, l1_perr;
  logic [CNT_W-1:0] l1_rd_cnt, l1_wr_cnt;
  logic [1:0]       l1_state;

  mem_line_responder #(.LATENCY(4), .ADDR_W(10), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .dbg_state(dbg_state)
  );

  mem_line_responder #(.LATENCY(1), .ADDR_W(10), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .mem_read(l1_read), .mem_write(l1_write), .mem_addr(l1_addr),
    .mem_wdata(l1_wdata), .mem_rdata(l1_rdata), .mem_ready(l1_ready),
    .proto_err(l1_perr), .rd_cnt(l1_rd_cnt), .wr_cnt(l1_wr_cnt),
    .dbg_state(l1_state)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks (LATENCY=4 instance)
  task automatic start_req(input logic rd, input logic wr, input logic [27:0] a,
                           input logic [127:0] d);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic drop_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Returns the cycle index of the ready pulse, 0 if none within the budget.
  task automatic wait_ready(output int n, output logic [127:0] data);
    n    = 0;
    data = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        n    = i;
        data = mem_rdata;
        break;
      end
    end
  endtask

  // Full transaction: latency, optional read data, single-cycle ready.
  task automatic do_txn(input string tag, input logic rd, input logic wr,
                        input logic [27:0] a, input logic [127:0] d,
                        input bit chk_data, input logic [127:0] exp_data);
    int n;
    logic [127:0] got;
    start_req(rd, wr, a, d);
    wait_ready(n, got);
    check({tag, "_lat"}, 128'(n), 128'(4));
    if (chk_data) check({tag, "_rdata"}, got, exp_data);
    drop_req();
    @(negedge clk);
    check({tag, "_once"}, 128'(mem_ready), 128'(0));
  endtask

  task automatic l1_txn(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, output int n, output logic [127:0] data);
    @(negedge clk);
    l1_read  = rd;
    l1_write = wr;
    l1_addr  = a;
    l1_wdata = d;
    n    = 0;
    data = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (l1_ready) begin
        n    = i;
        data = l1_rdata;
        break;
      end
    end
    l1_read  = 1'b0;
    l1_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    bit seen;
    logic [127:0] got;

    mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    l1_read = 0; l1_write = 0; l1_addr = '0; l1_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(mem_ready), 128'(0));
    check("rst_rdata", mem_rdata, 128'(0));
    check("rst_perr", 128'(proto_err), 128'(0));
    check("rst_rdcnt", 128'(rd_cnt), 128'(0));
    check("rst_wrcnt", 128'(wr_cnt), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    proc_reset_n = 1'b1;
    @(negedge clk);

    // 1: write then read, ready in cycle 4
    do_txn("t1_wr", 1'b0, 1'b1, 28'h0000012, D1, 1'b0, '0);
    check("t1_wrcnt", 128'(wr_cnt), 128'(1));
    do_txn("t1_rd", 1'b1, 1'b0, 28'h0000012, '0, 1'b1, D1);
    check("t1_rdcnt", 128'(rd_cnt), 128'(1));

    // 2: back-to-back write 0x5 then read 0x7
    do_txn("t2_pre", 1'b0, 1'b1, 28'h0000007, D7, 1'b0, '0);
    start_req(1'b0, 1'b1, 28'h0000005, D5);
    wait_ready(n, got);
    check("t2_lat1", 128'(n), 128'(4));
    mem_read = 1'b1; mem_write = 1'b0; mem_addr = 28'h0000007; mem_wdata = '0;
    wait_ready(n2, got);
    check("t2_gap", 128'(n2), 128'(5));
    check("t2_rdata", got, D7);
    drop_req();
    @(negedge clk);
    check("t2_once", 128'(mem_ready), 128'(0));
    check("t2_wrcnt", 128'(wr_cnt), 128'(3));
    check("t2_rdcnt", 128'(rd_cnt), 128'(2));

    // 3: aliasing above ADDR_W
    do_txn("t3_wr", 1'b0, 1'b1, 28'h0000403, DA, 1'b0, '0);
    do_txn("t3_rd", 1'b1, 1'b0, 28'h0000003, '0, 1'b1, DA);
    check("t3_perr", 128'(proto_err), 128'(0));

    // 4: read and write together -> write, proto_err
    do_txn("t4_both", 1'b1, 1'b1, 28'h0000009, DB, 1'b0, '0);
    check("t4_perr", 128'(proto_err), 128'(1));
    check("t4_wrcnt", 128'(wr_cnt), 128'(5));
    check("t4_rdcnt0", 128'(rd_cnt), 128'(3));
    do_txn("t4_rd", 1'b1, 1'b0, 28'h0000009, '0, 1'b1, DB);
    check("t4_perr_sticky", 128'(proto_err), 128'(1));

    // 5: read dropped in cycle 2 -> no ready
    start_req(1'b1, 1'b0, 28'h0000012, '0);
    repeat (2) @(negedge clk);
    drop_req();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    check("t5_noready", 128'(seen), 128'(0));
    check("t5_rdcnt", 128'(rd_cnt), 128'(4));
    check("t5_perr", 128'(proto_err), 128'(1));
    do_txn("t5_next", 1'b1, 1'b0, 28'h0000012, '0, 1'b1, D1);
    check("t5_rdcnt2", 128'(rd_cnt), 128'(5));

    // 6: reset during WAIT of a write to 0x20
    do_txn("t6_pre", 1'b0, 1'b1, 28'h0000020, DP, 1'b0, '0);
    start_req(1'b0, 1'b1, 28'h0000020, DQ);
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b0;
    drop_req();
    @(negedge clk);
    check("t6_ready", 128'(mem_ready), 128'(0));
    check("t6_rdcnt", 128'(rd_cnt), 128'(0));
    check("t6_wrcnt", 128'(wr_cnt), 128'(0));
    check("t6_perr", 128'(proto_err), 128'(0));
    check("t6_state", 128'(dbg_state), 128'(0));
    proc_reset_n = 1'b1;
    do_txn("t6_rd", 1'b1, 1'b0, 28'h0000020, '0, 1'b1, DP);
    check("t6_rdcnt1", 128'(rd_cnt), 128'(1));

    // 7: address change while waiting -> latched address used
    start_req(1'b1, 1'b0, 28'h0000005, '0);
    repeat (2) @(negedge clk);
    mem_addr = 28'h0000007;
    wait_ready(n, got);
    check("t7_lat", 128'(n), 128'(2));
    check("t7_rdata", got, D5);
    check("t7_perr", 128'(proto_err), 128'(1));
    drop_req();
    @(negedge clk);

    // 8: LATENCY=1 instance
    l1_txn(1'b0, 1'b1, 28'h0000001, DE, n, got);
    check("l1_wr_lat", 128'(n), 128'(1));
    l1_txn(1'b1, 1'b0, 28'h0000001, '0, n, got);
    check("l1_rd_lat", 128'(n), 128'(1));
    check("l1_rdata", got, DE);
    @(negedge clk);
    check("l1_once", 128'(l1_ready), 128'(0));
    check("l1_rdcnt", 128'(l1_rd_cnt), 128'(1));
    check("l1_wrcnt", 128'(l1_wr_cnt), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
